demux_1to2_stream: RTL
======================

DEMUX_1TO2_STREAM -- requirements
Module: demux_1to2_stream

Interface
REQ-001 Parameter: DATA_W, default 8, payload width in bits.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream beat present.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 in_data  input  DATA_W  upstream payload.
REQ-008 in_last  input  1  final beat of packet.
REQ-009 in_sel  input  1  destination: 0 = port A, 1 = port B.
REQ-010 a_valid / b_valid  output  1  port A / B beat present.
REQ-011 a_ready / b_ready  input  1  port A / B sink accepts.
REQ-012 a_data / b_data  output  DATA_W  port A / B payload.
REQ-013 a_last / b_last  output  1  port A / B final beat.
REQ-014 a_count / b_count  output  16  beats delivered per port; present only with DEMUX_COUNT_EN.

Function
REQ-015 The block SHALL accept a beat on a cycle when in_valid && in_ready; a port SHALL complete a transfer on a cycle when x_valid && x_ready.
REQ-016 Each port SHALL have a one-entry output register (valid, data, last); accept-to-x_valid latency SHALL be exactly 1 cycle.
REQ-017 The FSM SHALL have states IDLE, LOCK_A and LOCK_B.
REQ-018 In IDLE, the target SHALL be in_sel. On an accepted beat with in_last=0, the FSM SHALL go to LOCK_A or LOCK_B per in_sel. With in_last=1, it SHALL stay in IDLE.
REQ-019 In LOCK_x, the target SHALL be port x and in_sel SHALL be ignored. An accepted beat with in_last=1 SHALL return the FSM to IDLE.
REQ-020 in_ready SHALL be 1 iff the target register is empty or is completing a transfer in the same cycle. in_ready SHALL NOT depend on in_valid.
REQ-021 Simultaneous port transfer and new accept to the same port: the register SHALL reload and x_valid SHALL stay 1, with no bubble.
REQ-022 While x_valid && !x_ready, x_data and x_last SHALL be held stable.
REQ-023 The non-target port SHALL drain independently of upstream activity.
REQ-024 No beat SHALL ever be duplicated, dropped or delivered to both ports.

Reset
REQ-025 While rst=1, the FSM SHALL be IDLE, and a_valid, b_valid, a_last, b_last, a_data and b_data SHALL all be 0. in_ready SHALL be 0 during reset and SHALL be 1 in the first cycle after reset.
REQ-026 Reset mid-packet SHALL discard the partial packet and all buffered beats. The next accepted beat SHALL be treated as a packet start.
REQ-027 With DEMUX_COUNT_EN, reset SHALL clear a_count and b_count to 0.

Configuration
REQ-028 Macro DEMUX_COUNT_EN defined: each counter SHALL increment by 1 on every transfer of its port and SHALL wrap from 0xFFFF to 0x0000.
REQ-029 Macro DEMUX_COUNT_EN undefined: the a_count and b_count ports and their counter logic SHALL be absent. All other behaviour SHALL be identical.

Structure
REQ-030 A shared package demux_pkg SHALL hold the FSM state enum (IDLE, LOCK_A, LOCK_B) and the constants SEL_A=0, SEL_B=1 and COUNT_W=16.
REQ-031 The per-port register SHALL be a sub-module named stream_out_reg, instantiated twice.

Verification
REQ-032 Single beat: in_sel=1, in_data=0x5A, in_last=1, b_ready=1 -> b_valid=1 and b_data=0x5A one cycle later; a_valid stays 0; FSM stays IDLE.
REQ-033 Lock: 4-beat packet 0x10..0x13, with in_sel=0 on beat 0 and in_sel toggled on beats 1-3 -> all 4 beats on port A in order, a_last=1 only with 0x13.
REQ-034 Backpressure: a_ready=0 for 5 cycles with a 2-beat packet to A -> in_ready=0 after first accept; a_data stays 0x10 stable; on a_ready=1, beats 0x10 then 0x11 delivered back-to-back.
REQ-035 Interleave: packet to A stalled by a_ready=0 while B still holds an undrained beat -> b_valid drains when b_ready=1; nothing leaks from A to B.
REQ-036 Reset mid-packet: rst=1 after beat 1 of a 3-beat packet to B -> b_valid=0 next cycle; a new beat with in_sel=0 then goes to A.
REQ-037 With DEMUX_COUNT_EN: preload by driving 65535 transfers on A -> a_count=0xFFFF; one more transfer -> a_count=0x0000; b_count unchanged.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer.
//   state_t : packet-lock FSM encoding (IDLE, LOCK_A, LOCK_B)
//   SEL_A   : in_sel value that routes to port A
//   SEL_B   : in_sel value that routes to port B
//   COUNT_W : width of the optional per-port beat counters
package demux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  localparam logic SEL_A   = 1'b0;
  localparam logic SEL_B   = 1'b1;
  localparam int   COUNT_W = 16;

endpackage

// File: rtl/stream_out_reg.sv
// One-entry output register for a single demux port (valid, data, last).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_load     : upstream beat accepted for this port this cycle
//   i_data     : payload to capture on i_load
//   i_last     : last flag to capture on i_load
//   i_ready    : downstream sink ready
//   o_valid    : beat present towards the sink
//   o_data     : held payload
//   o_last     : held last flag
//   o_free     : register can take a beat this cycle (empty or draining)
module stream_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_free
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;

  // A load during a draining cycle reloads the register so o_valid stays high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/demux_1to2_stream.sv
// Packet-aware 1-to-2 stream demultiplexer. The first beat of a packet picks
// the destination from in_sel; the rest of the packet follows it regardless
// of in_sel. Each output port has its own one-entry register, so an idle
// port drains independently of the other.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid/in_ready         : upstream handshake
//   in_data/in_last/in_sel    : upstream payload, end-of-packet, destination
//   a_valid/a_ready/a_data/a_last : port A stream
//   b_valid/b_ready/b_data/b_last : port B stream
//   a_count/b_count           : beats delivered per port (wrapping, 16 bit),
//                               present only when DEMUX_COUNT_EN is defined
// Build option: define DEMUX_COUNT_EN to add the per-port beat counters.
module demux_1to2_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_sel,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [DATA_W-1:0] a_data,
  output logic              a_last,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [DATA_W-1:0] b_data,
  output logic              b_last
`ifdef DEMUX_COUNT_EN
  ,
  output logic [COUNT_W-1:0] a_count,
  output logic [COUNT_W-1:0] b_count
`endif
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_target;
  logic   w_accept;
  logic   w_a_free;
  logic   w_b_free;
  logic   w_load_a;
  logic   w_load_b;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_target    = in_sel;
    case (r_state)
      IDLE: begin
        w_target = in_sel;
        if (w_accept && !in_last)
          w_state_nxt = (in_sel == SEL_B) ? LOCK_B : LOCK_A;
      end
      LOCK_A: begin
        w_target = SEL_A;
        if (w_accept && in_last) w_state_nxt = IDLE;
      end
      LOCK_B: begin
        w_target = SEL_B;
        if (w_accept && in_last) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Ready follows only the target register; gated low while reset is held.
  assign in_ready = !rst && ((w_target == SEL_B) ? w_b_free : w_a_free);
  assign w_accept = in_valid && in_ready;
  assign w_load_a = w_accept && (w_target == SEL_A);
  assign w_load_b = w_accept && (w_target == SEL_B);

  stream_out_reg #(.DATA_W(DATA_W)) u_reg_a (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load_a),
    .i_data  (in_data),
    .i_last  (in_last),
    .i_ready (a_ready),
    .o_valid (a_valid),
    .o_data  (a_data),
    .o_last  (a_last),
    .o_free  (w_a_free)
  );

  stream_out_reg #(.DATA_W(DATA_W)) u_reg_b (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load_b),
    .i_data  (in_data),
    .i_last  (in_last),
    .i_ready (b_ready),
    .o_valid (b_valid),
    .o_data  (b_data),
    .o_last  (b_last),
    .o_free  (w_b_free)
  );

`ifdef DEMUX_COUNT_EN
  logic [COUNT_W-1:0] r_a_count;
  logic [COUNT_W-1:0] r_b_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_count <= '0;
      r_b_count <= '0;
    end else begin
      if (a_valid && a_ready) r_a_count <= r_a_count + 1'b1;
      if (b_valid && b_ready) r_b_count <= r_b_count + 1'b1;
    end
  end

  assign a_count = r_a_count;
  assign b_count = r_b_count;
`endif

endmodule
